// File: rtl/vga_pkg.sv
// Shared definitions for the VGA index-framebuffer write path.
//   H_RES / V_RES : visible raster size; H_RES is also the framebuffer row stride
//   AW / DW       : framebuffer address and palette index widths
//   FB_SIZE       : number of framebuffer locations (max address is FB_SIZE-1)
//   state_t       : fill FSM states, shared so benches and debug taps decode them alike
package vga_pkg;
   localparam int H_RES   = 640;
   localparam int V_RES   = 480;
   localparam int AW      = 19;
   localparam int DW      = 8;
   localparam int FB_SIZE = H_RES * V_RES;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VS = 2'd1,
      FILL    = 2'd2,
      DONE    = 2'd3
   } state_t;
endpackage

// File: rtl/vga_rect_writer_if.sv
// Rectangle fill command channel.
//   master : issuer (game/menu logic) drives cmd_valid and the command fields
//   slave  : fill engine drives cmd_ready
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both 1. The fields are sampled only on that edge; cmd_ready
// stays 0 while a command is in progress.
interface vga_rect_writer_if;
   import vga_pkg::*;

   logic          cmd_valid;
   logic          cmd_ready;
   logic [9:0]    cmd_x;
   logic [8:0]    cmd_y;
   logic [9:0]    cmd_w;
   logic [8:0]    cmd_h;
   logic [DW-1:0] cmd_color;
   logic          cmd_sync;

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_sync,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_sync,
      output cmd_ready
   );
endinterface

// File: rtl/vga_rect_clip.sv
// Combinational clip of a rectangle against the visible raster.
//   x, y   : top-left corner
//   w, h   : width / height
//   xe, ye : exclusive right / bottom edge, clamped to H_RES / V_RES
//   empty  : nothing of the rectangle lies on screen
module vga_rect_clip
   import vga_pkg::*;
(
   input  logic [9:0]  x,
   input  logic [8:0]  y,
   input  logic [9:0]  w,
   input  logic [8:0]  h,
   output logic [10:0] xe,
   output logic [9:0]  ye,
   output logic        empty
);
   logic [10:0] x_sum;
   logic [9:0]  y_sum;

   // One extra bit on each sum so x+w / y+h cannot wrap before the clamp.
   always_comb begin
      x_sum = {1'b0, x} + {1'b0, w};
      y_sum = {1'b0, y} + {1'b0, h};
      xe    = (x_sum > 11'(H_RES)) ? 11'(H_RES) : x_sum;
      ye    = (y_sum > 10'(V_RES)) ? 10'(V_RES) : y_sum;
      empty = (w == 10'd0) || (h == 9'd0) ||
              ({1'b0, x} >= 11'(H_RES)) || ({1'b0, y} >= 10'(V_RES));
   end
endmodule

// File: rtl/vga_rect_writer.sv
// Fills a clipped rectangle of one palette index into the 640x480 index
// framebuffer, one pixel per granted clock, in raster order.
//   iVGA_CLK, iRST_n : pixel clock, async active-low reset
//   cmd              : fill command channel (slave side)
//   iVS              : active-low vsync; cmd_sync commands wait for its falling edge
//   mem_gnt          : write port grant; 0 stalls the fill
//   oWR_EN/ADDR/DATA : framebuffer write port
//   busy, done       : command in progress / one-cycle completion pulse
//   pix_count        : pixels written by the current or last command
//   dbg_state        : FSM state tap
module vga_rect_writer
   import vga_pkg::*;
(
   input  logic                 iVGA_CLK,
   input  logic                 iRST_n,
   vga_rect_writer_if.slave     cmd,
   input  logic                 iVS,
   input  logic                 mem_gnt,
   output logic                 oWR_EN,
   output logic [AW-1:0]        oWR_ADDR,
   output logic [DW-1:0]        oWR_DATA,
   output logic                 busy,
   output logic                 done,
   output logic [18:0]          pix_count,
   output state_t               dbg_state
);
   state_t        state, state_nxt;
   logic          vs_q;
   logic [9:0]    x0, col;
   logic [8:0]    row;
   logic [10:0]   xe;
   logic [9:0]    ye;
   logic [AW-1:0] row_base;
   logic [DW-1:0] color;

   logic [10:0]   clip_xe;
   logic [9:0]    clip_ye;
   logic          clip_empty;

   logic          accept, vs_fall, wr, last_col, last_row;

   vga_rect_clip u_clip (
      .x     (cmd.cmd_x),
      .y     (cmd.cmd_y),
      .w     (cmd.cmd_w),
      .h     (cmd.cmd_h),
      .xe    (clip_xe),
      .ye    (clip_ye),
      .empty (clip_empty)
   );

   assign cmd.cmd_ready = (state == IDLE);
   assign accept        = cmd.cmd_valid && (state == IDLE);
   assign vs_fall       = vs_q && !iVS;
   assign wr            = (state == FILL) && mem_gnt;
   assign last_col      = ({1'b0, col} == (xe - 11'd1));
   assign last_row      = ({1'b0, row} == (ye - 10'd1));

   assign oWR_ADDR  = row_base + AW'(col);
   assign oWR_DATA  = color;
   assign dbg_state = state;

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state <= IDLE;
         vs_q  <= 1'b1;
      end else begin
         state <= state_nxt;
         vs_q  <= iVS;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = (state == DONE);
      oWR_EN    = wr;
      case (state)
         IDLE: begin
            if (accept) begin
               if (clip_empty)        state_nxt = DONE;
               else if (cmd.cmd_sync) state_nxt = WAIT_VS;
               else                   state_nxt = FILL;
            end
         end
         WAIT_VS: if (vs_fall) state_nxt = FILL;
         FILL:    if (wr && last_col && last_row) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Address counters. The last pixel leaves them untouched so oWR_ADDR
   // never points past the framebuffer, and an empty command parks them at 0.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         x0        <= '0;
         col       <= '0;
         row       <= '0;
         xe        <= '0;
         ye        <= '0;
         row_base  <= '0;
         color     <= '0;
         pix_count <= '0;
      end else if (accept) begin
         xe        <= clip_xe;
         ye        <= clip_ye;
         color     <= cmd.cmd_color;
         pix_count <= '0;
         if (clip_empty) begin
            x0       <= '0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
         end else begin
            x0       <= cmd.cmd_x;
            col      <= cmd.cmd_x;
            row      <= cmd.cmd_y;
            // y*640 = y*512 + y*128
            row_base <= AW'({cmd.cmd_y, 9'b0}) + AW'({cmd.cmd_y, 7'b0});
         end
      end else if (wr) begin
         pix_count <= pix_count + 19'd1;
         if (!last_col) begin
            col <= col + 10'd1;
         end else if (!last_row) begin
            col      <= x0;
            row      <= row + 9'd1;
            row_base <= row_base + AW'(H_RES);
         end
      end
   end
endmodule
